// File: rtl/inst_seq.sv
// Instruction sequencer: one start pulse walks n_kij rounds of weight load, activation execute and psum write-back.
// All outputs registered from next-state decode; define INST_SEQ_OFIFO_WAIT_EN to hold OPRE until ofifo_valid.
module inst_seq #(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int len_nij = 36,
  parameter int nij_sz  = 6,
  parameter int n_kij   = 9
) (
  input  logic        clk,
  input  logic        reset,
`ifdef INST_SEQ_OFIFO_WAIT_EN
  input  logic        ofifo_valid,
`endif
  input  logic        start,
  output logic [33:0] inst,
  output logic        mode,
  output logic        sel,
  output logic        core_reset,
  output logic [3:0]  kij,
  output logic        busy,
  output logic        done
);

  localparam int TW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_WL0, S_KLD, S_GAP, S_AL0, S_EXE, S_OPRE, S_PWR, S_DRN, S_FIN
  } state_t;

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  localparam inst_t IDLE_INST = inst_t'(34'h1800C0000);

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [3:0]    kij_q, kij_d;
  inst_t         inst_q, inst_d;
  logic          core_reset_q, core_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last;
  int            t_di, kij_di, off;

  function automatic int dur(input state_t s);
    case (s)
      S_CRST:  dur = 10;
      S_WL0:   dur = 2 * col;
      S_KLD:   dur = row + 2 * col;
      S_GAP:   dur = 10;
      S_AL0:   dur = len_nij;
      S_EXE:   dur = len_nij + 2 * col;
      S_PWR:   dur = len_nij;
      S_DRN:   dur = 3;
      default: dur = 1;
    endcase
  endfunction

  assign last = (int'(t_q) == dur(state_q) - 1);

  always_comb begin
    state_d = state_q;
    t_d     = t_q + TW'(1);
    kij_d   = kij_q;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start) state_d = S_CRST;
      end
      S_CRST: if (last) begin state_d = S_WL0; t_d = '0; end
      S_WL0:  if (last) begin state_d = S_KLD; t_d = '0; end
      S_KLD:  if (last) begin state_d = S_GAP; t_d = '0; end
      S_GAP:  if (last) begin state_d = S_AL0; t_d = '0; end
      S_AL0:  if (last) begin state_d = S_EXE; t_d = '0; end
      S_EXE:  if (last) begin state_d = S_OPRE; t_d = '0; end
      S_OPRE: begin
        t_d = '0;
`ifdef INST_SEQ_OFIFO_WAIT_EN
        // t=0 waits for ofifo_valid, t=1 is the single read cycle
        if (t_q == '0) t_d = ofifo_valid ? TW'(1) : '0;
        else           state_d = S_PWR;
`else
        state_d = S_PWR;
`endif
      end
      S_PWR:  if (last) begin state_d = S_DRN; t_d = '0; end
      S_DRN: begin
        if (last) begin
          t_d = '0;
          if (int'(kij_q) < n_kij - 1) begin
            state_d = S_CRST;
            kij_d   = kij_q + 4'd1;
          end else begin
            state_d = S_FIN;
            kij_d   = '0;
          end
        end
      end
      S_FIN: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output word for the cycle the next state occupies, so every output is a flop.
  always_comb begin
    t_di         = int'(t_d);
    kij_di       = int'(kij_d);
    off          = kij_di % 3 + (kij_di / 3) * nij_sz;
    inst_d       = IDLE_INST;
    core_reset_d = (state_d == S_CRST);
    busy_d       = !(state_d inside {S_IDLE, S_FIN});
    done_d       = (state_d == S_FIN);
    case (state_d)
      S_WL0: begin
        inst_d.cen_xmem = 1'b0;
        inst_d.l0_wr    = 1'b1;
        inst_d.a_xmem   = 11'(1024 + kij_di * 2 * col + t_di);
      end
      S_KLD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = (t_di < 2 * col);
      end
      S_AL0: begin
        inst_d.cen_xmem = 1'b0;
        inst_d.l0_wr    = 1'b1;
        inst_d.a_xmem   = 11'(t_di);
      end
      S_EXE: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = (t_di < len_nij);
      end
      S_OPRE: begin
        inst_d.acc = (kij_d != '0);
`ifdef INST_SEQ_OFIFO_WAIT_EN
        inst_d.ofifo_rd = (t_d == TW'(1));
`else
        inst_d.ofifo_rd = 1'b1;
`endif
      end
      S_PWR: begin
        inst_d.acc      = (kij_d != '0);
        inst_d.ofifo_rd = 1'b1;
        inst_d.cen_pmem = 1'b0;
        inst_d.wen_pmem = 1'b0;
        // negative offsets wrap modulo the 2048-entry psum memory
        inst_d.a_pmem   = 11'(t_di - off);
      end
      S_DRN: inst_d.acc = (kij_d != '0) && (t_d == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      kij_q        <= '0;
      inst_q       <= IDLE_INST;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      kij_q        <= kij_d;
      inst_q       <= inst_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign inst       = inst_q;
  assign mode       = 1'b0;
  assign sel        = kij_q[0];
  assign core_reset = core_reset_q;
  assign kij        = kij_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_inst_seq.sv
// Directed bench for inst_seq: full pass timing, address patterns, mid-pass reset and start/reset priority.
module tb_inst_seq;

`ifdef INST_SEQ_OFIFO_WAIT_EN
  localparam int OP = 1;
`else
  localparam int OP = 0;
`endif
  localparam int PER    = 188 + OP;
  localparam int O_OPRE = 148 + OP;
  localparam int O_PWR  = 149 + OP;
  localparam int O_DRN  = 185 + OP;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;
  localparam logic [33:0] ACC_B  = 34'h200000000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [33:0] inst;
  logic        mode;
  logic        sel;
  logic        core_reset;
  logic [3:0]  kij;
  logic        busy;
  logic        done;
`ifdef INST_SEQ_OFIFO_WAIT_EN
  logic        ofifo_valid;
`endif

  int n_cmp;
  int n_err;

  inst_seq dut (
    .clk        (clk),
    .reset      (reset),
`ifdef INST_SEQ_OFIFO_WAIT_EN
    .ofifo_valid(ofifo_valid),
`endif
    .start      (start),
    .inst       (inst),
    .mode       (mode),
    .sel        (sel),
    .core_reset (core_reset),
    .kij        (kij),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs at cycle c after the start edge, from the hand-derived 188-cycle round layout.
  task automatic check_cycle(input int c);
    int k;
    int o;
    logic [13:0] wl;
    logic [14:0] pw;
    k = c / PER;
    o = c % PER;
    chk("kij", kij, k);
    chk("sel", sel, k % 2);
    chk("busy", busy, 1);
    chk("done", done, 0);
    chk("core_reset", core_reset, (o < 10));
    if (o < 10 || (o >= 50 && o < 60)) chk("idle_word", inst, IDLE_W);
    if ((k == 0 || k == 2) && o >= 10 && o < 26) begin
      wl = {1'b0, 1'b1, 1'b1, 11'(1024 + 16 * k + o - 10)};
      chk("wl0", {inst[19], inst[18], inst[2], inst[17:7]}, wl);
    end
    if (k == 0 && o >= 26 && o < 50) chk("kld", {inst[3], inst[0]}, {1'b1, (o < 42)});
    if (k == 0 && o >= 60 && o < 96) chk("al0", {inst[19], inst[2], inst[17:7]}, {1'b0, 1'b1, 11'(o - 60)});
    if (k == 0 && o >= 96 && o < 148) chk("exe", {inst[3], inst[1]}, {1'b1, (o < 132)});
    if (o == O_OPRE) chk("opre", {inst[33], inst[6], inst[32]}, {(k > 0), 1'b1, 1'b1});
    if (k == 4 && o >= O_PWR && o < O_DRN) begin
      pw = {4'b1001, 11'((2041 + o - O_PWR) % 2048)};
      chk("pwr_k4", {inst[33], inst[32], inst[31], inst[6], inst[30:20]}, pw);
    end
    if (k == 0 && o >= O_PWR && o < O_DRN) begin
      pw = {4'b0001, 11'(o - O_PWR)};
      chk("pwr_k0", {inst[33], inst[32], inst[31], inst[6], inst[30:20]}, pw);
    end
    if (o >= O_DRN) chk("drn", inst, (o == O_DRN && k > 0) ? (IDLE_W | ACC_B) : IDLE_W);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
`ifdef INST_SEQ_OFIFO_WAIT_EN
    ofifo_valid = 1'b1;
`endif
    repeat (5) tick();
    chk("rst_inst", inst, IDLE_W);
    chk("rst_kij", kij, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_reset", core_reset, 0);
    chk("mode", mode, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Full pass; a stray start mid-pass must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9 * PER; c++) begin
      check_cycle(c);
      start = (c == 300);
      tick();
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_kij", kij, 0);
    chk("fin_inst", inst, IDLE_W);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    repeat (3) tick();
    chk("stay_idle", {busy, done, core_reset}, 3'b000);

    // Reset in the middle of kij=3 EXE.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3 * PER + 110; c++) begin
      check_cycle(c);
      tick();
    end
    chk("mid_exe", {kij, inst[1], inst[3]}, {4'd3, 1'b1, 1'b1});
    reset = 1'b1;
    tick();
    chk("abort_inst", inst, IDLE_W);
    chk("abort_kij", kij, 0);
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 0);
    chk("abort_done", done, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    tick();
    chk("rst_start_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_idle", busy, 0);

    // Restart runs from kij=0, not from the abandoned round.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < PER + 30; c++) begin
      check_cycle(c);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

`ifdef INST_SEQ_OFIFO_WAIT_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 148; c++) begin
      if (c == 140) ofifo_valid = 1'b0;
      tick();
    end
    repeat (20) begin
      chk("opre_hold_rd", inst[6], 0);
      chk("opre_hold_pmem", inst[32], 1);
      tick();
    end
    ofifo_valid = 1'b1;
    chk("opre_wait_rd", inst[6], 0);
    tick();
    chk("opre_rd", {inst[6], inst[32]}, 2'b11);
    tick();
    chk("pwr_entry", {inst[6], inst[32], inst[30:20]}, {1'b1, 1'b0, 11'd0});
    tick();
    chk("pwr_second", {inst[6], inst[30:20]}, {1'b1, 11'd1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
